epb_slave_sequencer: RTL and testbench
======================================

Name: epb_slave_sequencer

Overview:
- Sequences EPB slave transactions arriving from the EPB pad-buffer infrastructure onto an internal single-outstanding req/ack register bus.
- Registers the buffered EPB control, address and data inputs. Issues one internal bus request per chip-select assertion.
- Returns read data and drives the data output enable, the ready pulse and the ready output enable back to the infrastructure.
- Sits between the EPB infrastructure and the register and shared-memory decode logic, all in the epb_clk domain.

Parameters:
- ADDR_W, 29, internal bus address width = {epb_addr_gp[5:0], epb_addr[22:0]}.
- TIMEOUT, 1023, epb_clk cycles in WAIT without bus_ack before the sequencer self-completes (1..65535).
- TIMEOUT_DATA, 16'hDEAD, read data returned on timeout.

Ports:
- epb_clk  in  1  clock, EPB bus clock
- epb_rst  in  1  reset, synchronous, active-high
- epb_cs_n  in  1  buffered chip select, active-low
- epb_oe_n  in  1  buffered output enable, active-low
- epb_r_w_n  in  1  1=read, 0=write
- epb_be_n  in  2  byte enables, active-low
- epb_addr  in  23  word address
- epb_addr_gp  in  6  address extension bits
- epb_data_in  in  16  write data from pads
- epb_data_out  out  16  read data to pads
- epb_data_oe_n  out  1  pad data driver enable, active-low
- epb_rdy  out  1  transfer-complete pulse
- epb_rdy_oe  out  1  ready pad driver enable
- bus_req  out  1  internal request, held until ack
- bus_rnw  out  1  1=read
- bus_addr  out  ADDR_W  latched address
- bus_be  out  2  active-high byte enables (inverted epb_be_n)
- bus_wr_data  out  16  latched write data
- bus_ack  in  1  one-cycle completion from slave
- bus_rd_data  in  16  valid with bus_ack when bus_rnw=1
- timeout_err  out  1  sticky, set on any timeout

Behaviour:
- Input stage: all EPB inputs registered once (stage R). The FSM uses only R-stage values.
- Reset values: epb_data_out=0, epb_data_oe_n=1, epb_rdy=0, epb_rdy_oe=0, bus_req=0, bus_rnw=1, bus_addr=0, bus_be=0, bus_wr_data=0, timeout_err=0. The FSM enters IDLE and the counter clears.
- epb_rst clears all of the above immediately at the next edge, including mid-transaction. bus_req drops. No epb_rdy is emitted for the interrupted transfer.
- IDLE: on R cs_n=0, latch addr, be, r_w_n and data_in into the bus_* registers. Set bus_req=1 and epb_rdy_oe=1, then go to WAIT. Latency: EPB cs_n low at edge N gives bus_req high after edge N+2.
- WAIT: bus_req stays high and the counter increments each cycle.
  - On bus_ack: drop bus_req. If read, capture bus_rd_data into epb_data_out. Go to RDY.
  - If counter == TIMEOUT-1 with no ack: drop bus_req, set timeout_err. Read data becomes TIMEOUT_DATA and writes are discarded. Go to RDY.
  - If bus_ack and timeout occur in the same cycle, the ack wins and no error is flagged.
- RDY: epb_rdy=1 for exactly one cycle, then go to HOLD.
- HOLD: epb_rdy=0, epb_rdy_oe stays 1. When R cs_n=1, set epb_rdy_oe=0 and return to IDLE. cs_n is never re-sampled as a new request inside HOLD.
- Abort: if R cs_n goes high while in WAIT, bus_req is still held until ack or timeout, because the downstream cannot abort. The RDY pulse is then suppressed and the FSM goes directly to HOLD, which exits next cycle.
- epb_data_oe_n = 0 only when: read transaction, state is RDY or HOLD, R oe_n=0, and R cs_n=0. Otherwise it is 1.
- Counter: 16 bits, cleared on entry to WAIT. It saturates and never wraps.
- timeout_err is cleared only by epb_rst.
- At most one bus_req is outstanding at any time.

Optional Feature:
- Macro EPB_SEQ_TIMEOUT_EN.
- Defined: timeout counter, TIMEOUT_DATA and timeout_err behave as above.
- Undefined: no counter is synthesised. WAIT waits for bus_ack indefinitely, and timeout_err is tied 0.

Test Plan:
- Write: cs_n low, r_w_n=0, addr=23'h000123, addr_gp=6'h01, be_n=2'b00, data=16'hA5A5. Slave acks after 3 cycles. Required: bus_addr=29'h00800123, bus_be=2'b11, bus_wr_data=A5A5, bus_rnw=0, one epb_rdy pulse, epb_data_oe_n stays 1.
- Read: slave returns 16'h1234 with ack after 1 cycle, oe_n low. Required: epb_data_out=1234, epb_data_oe_n=0 from RDY until cs_n or oe_n deasserts, epb_rdy high for 1 cycle.
- Timeout (macro defined, TIMEOUT=8): read with no ack. Required: bus_req drops after 8 cycles in WAIT, epb_data_out=DEAD, timeout_err=1 and stays 1 over the next transaction.
- Abort: cs_n deasserted 2 cycles into WAIT, ack at cycle 5. Required: bus_req held until ack, no epb_rdy pulse, epb_rdy_oe low one cycle after HOLD entry.
- Reset mid-WAIT: epb_rst pulsed for 1 cycle. Required: all outputs at reset values next cycle, no epb_rdy. A subsequent write completes normally.
- Back-to-back: cs_n high for exactly 1 cycle between two reads. Required: two distinct bus_req assertions, two epb_rdy pulses, addresses latched correctly for each.

Source files
------------

// File: rtl/epb_slave_sequencer.sv
// epb_slave_sequencer
//   Turns buffered EPB slave accesses into single-outstanding req/ack
//   transactions on the internal register bus, all in the epb_clk domain.
//   Every EPB input passes through one register stage (R) and the FSM only
//   ever looks at the R copies.
//
// Ports
//   epb_clk, epb_rst      clock, synchronous active-high reset
//   epb_cs_n/oe_n/r_w_n   buffered EPB control (active-low cs/oe, 1=read)
//   epb_be_n, epb_addr,   byte enables, word address, address extension,
//   epb_addr_gp,          write data from the pads
//   epb_data_in
//   epb_data_out/_oe_n    read data and pad driver enable (active-low)
//   epb_rdy, epb_rdy_oe   one-cycle transfer-complete pulse, its pad enable
//   bus_req/rnw/addr/be/  internal request, held until bus_ack
//   bus_wr_data
//   bus_ack, bus_rd_data  one-cycle completion and read data from the slave
//   timeout_err           sticky timeout flag
//
// Build option
//   EPB_SEQ_TIMEOUT_EN    when defined, WAIT self-completes after TIMEOUT
//                         cycles without bus_ack (reads return TIMEOUT_DATA,
//                         timeout_err is set). When undefined, no counter is
//                         built and timeout_err is tied low.

module epb_slave_sequencer #(
  parameter int          ADDR_W       = 29,
  parameter int          TIMEOUT      = 1023,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic              epb_clk,
  input  logic              epb_rst,
  input  logic              epb_cs_n,
  input  logic              epb_oe_n,
  input  logic              epb_r_w_n,
  input  logic [1:0]        epb_be_n,
  input  logic [22:0]       epb_addr,
  input  logic [5:0]        epb_addr_gp,
  input  logic [15:0]       epb_data_in,
  output logic [15:0]       epb_data_out,
  output logic              epb_data_oe_n,
  output logic              epb_rdy,
  output logic              epb_rdy_oe,
  output logic              bus_req,
  output logic              bus_rnw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [1:0]        bus_be,
  output logic [15:0]       bus_wr_data,
  input  logic              bus_ack,
  input  logic [15:0]       bus_rd_data,
  output logic              timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RDY, S_HOLD} state_e;

  // R stage
  logic        cs_n_q, oe_n_q, rnw_q;
  logic [1:0]  be_n_q;
  logic [22:0] addr_q;
  logic [5:0]  gp_q;
  logic [15:0] din_q;

  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      cs_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      rnw_q  <= 1'b1;
      be_n_q <= 2'b11;
      addr_q <= '0;
      gp_q   <= '0;
      din_q  <= '0;
    end else begin
      cs_n_q <= epb_cs_n;
      oe_n_q <= epb_oe_n;
      rnw_q  <= epb_r_w_n;
      be_n_q <= epb_be_n;
      addr_q <= epb_addr;
      gp_q   <= epb_addr_gp;
      din_q  <= epb_data_in;
    end
  end

  state_e              state_q, state_d;
  logic                req_q, req_d, brnw_q, brnw_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [1:0]          bbe_q, bbe_d;
  logic [15:0]         bwd_q, bwd_d, dout_q, dout_d;
  logic                rdy_q, rdy_d, rdy_oe_q, rdy_oe_d;
  logic                abort_q, abort_d;
  logic                tmo_hit;

`ifdef EPB_SEQ_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        tmo_err_q;

  assign tmo_hit = (state_q == S_WAIT) && (cnt_q == 16'(TIMEOUT - 1));

  // Held at zero outside WAIT, so every WAIT entry starts from 0.
  // Saturates rather than wrapping.
  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q != S_WAIT)    cnt_q <= '0;
      else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      // A coincident ack wins: no error in that case.
      if (tmo_hit && !bus_ack) tmo_err_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    brnw_d   = brnw_q;
    baddr_d  = baddr_q;
    bbe_d    = bbe_q;
    bwd_d    = bwd_q;
    dout_d   = dout_q;
    rdy_d    = 1'b0;
    rdy_oe_d = rdy_oe_q;
    abort_d  = abort_q;
    unique case (state_q)
      S_IDLE: if (!cs_n_q) begin
        baddr_d  = ADDR_W'({gp_q, addr_q});
        bbe_d    = ~be_n_q;
        brnw_d   = rnw_q;
        bwd_d    = din_q;
        req_d    = 1'b1;
        rdy_oe_d = 1'b1;
        abort_d  = 1'b0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // The slave cannot be aborted: remember a cs_n release and keep
        // the request up until ack/timeout, then skip the ready pulse.
        if (cs_n_q) abort_d = 1'b1;
        if (bus_ack || tmo_hit) begin
          req_d = 1'b0;
          if (brnw_q) dout_d = bus_ack ? bus_rd_data : TIMEOUT_DATA;
          if (abort_q || cs_n_q) state_d = S_HOLD;
          else begin
            rdy_d   = 1'b1;
            state_d = S_RDY;
          end
        end
      end
      S_RDY:  state_d = S_HOLD;
      S_HOLD: if (cs_n_q) begin
        rdy_oe_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge epb_clk) begin
    if (epb_rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      brnw_q   <= 1'b1;
      baddr_q  <= '0;
      bbe_q    <= '0;
      bwd_q    <= '0;
      dout_q   <= '0;
      rdy_q    <= 1'b0;
      rdy_oe_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      brnw_q   <= brnw_d;
      baddr_q  <= baddr_d;
      bbe_q    <= bbe_d;
      bwd_q    <= bwd_d;
      dout_q   <= dout_d;
      rdy_q    <= rdy_d;
      rdy_oe_q <= rdy_oe_d;
      abort_q  <= abort_d;
    end
  end

  assign bus_req       = req_q;
  assign bus_rnw       = brnw_q;
  assign bus_addr      = baddr_q;
  assign bus_be        = bbe_q;
  assign bus_wr_data   = bwd_q;
  assign epb_data_out  = dout_q;
  assign epb_rdy       = rdy_q;
  assign epb_rdy_oe    = rdy_oe_q;
  // Pads drive only for a read that has completed, while the host still
  // holds both cs_n and oe_n low.
  assign epb_data_oe_n = ~(brnw_q && (state_q == S_RDY || state_q == S_HOLD) &&
                           !oe_n_q && !cs_n_q);

endmodule

// File: tb/tb_epb_slave_sequencer.sv
`timescale 1ns/1ps
module tb_epb_slave_sequencer;

  logic        epb_clk = 1'b0;
  logic        epb_rst = 1'b1;
  logic        epb_cs_n = 1'b1, epb_oe_n = 1'b1, epb_r_w_n = 1'b1;
  logic [1:0]  epb_be_n = 2'b11;
  logic [22:0] epb_addr = '0;
  logic [5:0]  epb_addr_gp = '0;
  logic [15:0] epb_data_in = '0;
  logic [15:0] epb_data_out;
  logic        epb_data_oe_n, epb_rdy, epb_rdy_oe;
  logic        bus_req, bus_rnw;
  logic [28:0] bus_addr;
  logic [1:0]  bus_be;
  logic [15:0] bus_wr_data;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rd_data = '0;
  logic        timeout_err;

  always #5 epb_clk = ~epb_clk;

  epb_slave_sequencer #(.ADDR_W(29), .TIMEOUT(8), .TIMEOUT_DATA(16'hDEAD)) dut (
    .epb_clk(epb_clk), .epb_rst(epb_rst), .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n),
    .epb_r_w_n(epb_r_w_n), .epb_be_n(epb_be_n), .epb_addr(epb_addr),
    .epb_addr_gp(epb_addr_gp), .epb_data_in(epb_data_in), .epb_data_out(epb_data_out),
    .epb_data_oe_n(epb_data_oe_n), .epb_rdy(epb_rdy), .epb_rdy_oe(epb_rdy_oe),
    .bus_req(bus_req), .bus_rnw(bus_rnw), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wr_data(bus_wr_data), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data),
    .timeout_err(timeout_err));

  typedef struct packed {
    logic        rnw;
    logic [28:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } req_t;

  typedef struct packed {
    logic        rnw;
    logic [15:0] data;
    logic        oe_n;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a rising bus_req pops the expected request, an epb_rdy pulse
  // pops the expected response.
  logic req_prev = 1'b0, rdy_prev = 1'b0;
  always @(negedge epb_clk) begin
    if (bus_req && !req_prev) begin
      chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
      if (exp_req_q.size() != 0) begin
        req_t e;
        e = exp_req_q.pop_front();
        chk("bus_rnw", 32'(bus_rnw), 32'(e.rnw));
        chk("bus_addr", 32'(bus_addr), 32'(e.addr));
        chk("bus_be", 32'(bus_be), 32'(e.be));
        chk("bus_wr_data", 32'(bus_wr_data), 32'(e.wdata));
      end
    end
    if (epb_rdy) begin
      chk("rdy_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
      chk("rdy_width", 32'(rdy_prev), 32'd0);
      if (exp_rsp_q.size() != 0) begin
        rsp_t r;
        r = exp_rsp_q.pop_front();
        if (r.rnw) chk("epb_data_out", 32'(epb_data_out), 32'(r.data));
        chk("data_oe_n_rdy", 32'(epb_data_oe_n), 32'(r.oe_n));
      end
    end
    req_prev = bus_req;
    rdy_prev = epb_rdy;
  end

  task automatic tick();
    @(posedge epb_clk);
    #1;
  endtask

  // Assert cs_n with one access; push expectations; confirm bus_req appears
  // two edges after the cs_n drive edge.
  task automatic start(input logic rnw, input logic [22:0] a, input logic [5:0] gp,
                       input logic [1:0] ben, input logic [15:0] d, input logic oe,
                       input logic want_rdy, input logic [15:0] rdv);
    req_t q;
    rsp_t s;
    int   n;
    q.rnw = rnw; q.addr = {gp, a}; q.be = ~ben; q.wdata = d;
    exp_req_q.push_back(q);
    if (want_rdy) begin
      s.rnw = rnw; s.data = rdv; s.oe_n = !(rnw && oe);
      exp_rsp_q.push_back(s);
    end
    epb_r_w_n = rnw; epb_addr = a; epb_addr_gp = gp; epb_be_n = ben;
    epb_data_in = d; epb_oe_n = !oe; epb_cs_n = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_req && n < 20);
    chk("req_latency", n, 2);
  endtask

  task automatic ack(input int dly, input logic [15:0] rd);
    repeat (dly - 1) tick();
    bus_rd_data = rd;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
  endtask

  // Called in RDY: check the pulse, the HOLD state, then release cs_n/oe_n.
  task automatic finish(input logic exp_oe_n);
    chk("rdy_pulse", 32'(epb_rdy), 32'd1);
    chk("req_dropped", 32'(bus_req), 32'd0);
    tick();
    chk("rdy_low_hold", 32'(epb_rdy), 32'd0);
    chk("rdy_oe_hold", 32'(epb_rdy_oe), 32'd1);
    chk("data_oe_n_hold", 32'(epb_data_oe_n), 32'(exp_oe_n));
    epb_cs_n = 1'b1;
    epb_oe_n = 1'b1;
    tick();
    chk("data_oe_n_release", 32'(epb_data_oe_n), 32'd1);
  endtask

  task automatic idle();
    tick();
    chk("rdy_oe_idle", 32'(epb_rdy_oe), 32'd0);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_out"}, 32'(epb_data_out), 32'd0);
    chk({tag, "_data_oe_n"}, 32'(epb_data_oe_n), 32'd1);
    chk({tag, "_rdy"}, 32'(epb_rdy), 32'd0);
    chk({tag, "_rdy_oe"}, 32'(epb_rdy_oe), 32'd0);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_rnw"}, 32'(bus_rnw), 32'd1);
    chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_be"}, 32'(bus_be), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus_wr_data), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) tick();
    epb_rst = 1'b0;
    chk_reset_vals("rst");
    tick();

    // Write: {01, 000123} -> 0x00800123, all bytes, ack 3 cycles into WAIT
    start(1'b0, 23'h000123, 6'h01, 2'b00, 16'hA5A5, 1'b0, 1'b1, 16'h0000);
    ack(3, 16'h0000);
    finish(1'b1);
    idle();

    // Read with oe_n low, ack after 1 cycle
    start(1'b1, 23'h0004AB, 6'h3F, 2'b01, 16'h0000, 1'b1, 1'b1, 16'h1234);
    ack(1, 16'h1234);
    finish(1'b0);
    chk("read_data_held", 32'(epb_data_out), 32'h1234);
    idle();

`ifdef EPB_SEQ_TIMEOUT_EN
    // Timeout read: no ack, request lasts exactly 8 WAIT cycles
    start(1'b1, 23'h7FFFFF, 6'h2A, 2'b10, 16'h5555, 1'b1, 1'b1, 16'hDEAD);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus_req && n < 40);
    chk("tmo_req_cycles", n, 8);
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    finish(1'b0);
    idle();
`endif

    // Back-to-back reads, cs_n high for one cycle between them
    start(1'b1, 23'h012345, 6'h02, 2'b00, 16'h1111, 1'b1, 1'b1, 16'hBEEF);
    ack(2, 16'hBEEF);
    finish(1'b0);
    start(1'b1, 23'h054321, 6'h10, 2'b10, 16'h2222, 1'b0, 1'b1, 16'h0F0F);
    ack(1, 16'h0F0F);
    finish(1'b1);
    idle();
`ifdef EPB_SEQ_TIMEOUT_EN
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
    chk("tmo_err_tied", 32'(timeout_err), 32'd0);
`endif

    // Abort: cs_n released 2 cycles into WAIT, ack sampled at cycle 5
    start(1'b0, 23'h000777, 6'h05, 2'b01, 16'hC3C3, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    epb_cs_n = 1'b1;
    tick();
    tick();
    chk("abort_req_held", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("abort_req_drop", 32'(bus_req), 32'd0);
    chk("abort_no_rdy", 32'(epb_rdy), 32'd0);
    chk("abort_rdy_oe_hold", 32'(epb_rdy_oe), 32'd1);
    tick();
    chk("abort_rdy_oe_off", 32'(epb_rdy_oe), 32'd0);
    tick();

    // Reset pulse mid-WAIT, then a normal write
    start(1'b0, 23'h000042, 6'h00, 2'b10, 16'h9999, 1'b0, 1'b0, 16'h0000);
    tick();
    epb_rst = 1'b1;
    epb_cs_n = 1'b1;
    tick();
    epb_rst = 1'b0;
    chk_reset_vals("midrst");
    tick();
    chk("midrst_no_rdy", 32'(epb_rdy), 32'd0);
    tick();
    start(1'b0, 23'h000ABC, 6'h3C, 2'b01, 16'h7E7E, 1'b0, 1'b1, 16'h0000);
    ack(2, 16'h0000);
    finish(1'b1);
    idle();

    chk("pending_req", exp_req_q.size(), 0);
    chk("pending_rsp", exp_rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
